// File: rtl/link_frame_pkg.sv
// Shared types, CRC-16/CCITT-FALSE and LFSR helpers for the link framer.
// Used by both the transmit framer and the receive-side monitor.
package link_frame_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2,
    ST_CRC   = 2'd3
  } tx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  function automatic logic [15:0] crc16_word(
    input logic [15:0] crc,
    input logic [15:0] data
  );
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]
                   ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/link_frame_if.sv
// Payload-in / frame-out handshake bundle of the link framer.
// master is the framer view, slave is the source/sink view.
interface link_frame_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sof;
  logic        m_eof;
  logic        m_train;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eof, m_train
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eof, m_train
  );
endinterface

// File: rtl/link_frame_tx_crc.sv
// CRC-16 accumulator register for the link framer.
// Clear wins over enable; clear reloads CRC16_INIT.
module frame_crc16
  import link_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC16_INIT;
    else if (en) crc_d = crc16_word(crc_q, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/link_frame_tx.sv
// Transmit framer: FRAME_WORDS payload/training words plus CRC-16 per frame.
// Optional CRC error injection with `define TX_ERR_INJECT_EN.
module link_frame_tx
  import link_frame_pkg::*;
#(
  parameter int          FRAME_WORDS   = 8,
  parameter logic [15:0] TRAIN_PATTERN = 16'hA5C3,
  parameter logic [31:0] LFSR_SEED     = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         link_up,
  link_frame_if.master bus,
`ifdef TX_ERR_INJECT_EN
  input  logic [15:0]  err_prob,
  output logic [31:0]  err_injected,
`endif
  output logic [1:0]   tx_state,
  output logic [31:0]  data_frames,
  output logic [31:0]  train_frames
);

  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_WORDS - 1);

  tx_state_e        state_q, state_d, boundary;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             train_q, train_d;
  logic             m_valid_q, m_valid_d;
  logic [15:0]      m_data_q, m_data_d;
  logic             m_sof_q, m_sof_d;
  logic             m_eof_q, m_eof_d;
  logic             m_train_q, m_train_d;
  logic [31:0]      data_frames_q, data_frames_d;
  logic [31:0]      train_frames_q, train_frames_d;
  logic             load, hs_eof;
  logic             crc_clr, crc_en;
  logic [15:0]      crc_in, crc_val;
  logic             inj;

`ifdef TX_ERR_INJECT_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        inj_q, inj_d;

  assign inj          = inj_q && !train_q;
  assign err_injected = err_cnt_q;
`else
  logic unused_seed;
  assign inj         = 1'b0;
  assign unused_seed = ^LFSR_SEED;
`endif

  frame_crc16 u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (crc_in),
    .crc  (crc_val)
  );

  // The CRC slot also acts as the frame boundary so frames abut.
  always_comb begin
    load     = !m_valid_q || bus.m_ready;
    hs_eof   = m_valid_q && bus.m_ready && m_eof_q;
    boundary = !link_up ? ST_TRAIN
             : (bus.s_valid ? ST_DATA : ST_START);

    state_d        = state_q;
    idx_d          = idx_q;
    train_d        = train_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_sof_d        = m_sof_q;
    m_eof_d        = m_eof_q;
    m_train_d      = m_train_q;
    data_frames_d  = data_frames_q;
    train_frames_d = train_frames_q;
    crc_clr        = 1'b0;
    crc_en         = 1'b0;
    crc_in         = bus.s_data;
`ifdef TX_ERR_INJECT_EN
    lfsr_d    = lfsr_q;
    inj_d     = inj_q;
    err_cnt_d = err_cnt_q;
`endif

    if (load) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
      unique case (state_q)
        ST_START: begin
          crc_clr = 1'b1;
          state_d = boundary;
        end
        ST_TRAIN: begin
          m_valid_d = 1'b1;
          m_data_d  = TRAIN_PATTERN;
          m_sof_d   = (idx_q == '0);
          m_train_d = 1'b1;
          train_d   = 1'b1;
          crc_en    = 1'b1;
          crc_in    = TRAIN_PATTERN;
          idx_d     = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = ST_CRC;
          end
        end
        ST_DATA: begin
          if (bus.s_valid) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_data;
            m_sof_d   = (idx_q == '0);
            m_train_d = 1'b0;
            train_d   = 1'b0;
            crc_en    = 1'b1;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST) begin
              idx_d   = '0;
              state_d = ST_CRC;
            end
`ifdef TX_ERR_INJECT_EN
            if (idx_q == '0) begin
              inj_d  = (lfsr_q[31:16] < err_prob);
              lfsr_d = lfsr_next(lfsr_q);
            end
`endif
          end
        end
        ST_CRC: begin
          m_valid_d = 1'b1;
          m_data_d  = crc_val ^ {15'd0, inj};
          m_eof_d   = 1'b1;
          m_train_d = train_q;
          crc_clr   = 1'b1;
          state_d   = boundary;
        end
      endcase
    end

    if (hs_eof) begin
      if (m_train_q) train_frames_d = train_frames_q + 32'd1;
      else           data_frames_d  = data_frames_q + 32'd1;
`ifdef TX_ERR_INJECT_EN
      if (!m_train_q && inj_q) err_cnt_d = err_cnt_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_START;
      idx_q          <= '0;
      train_q        <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_sof_q        <= 1'b0;
      m_eof_q        <= 1'b0;
      m_train_q      <= 1'b0;
      data_frames_q  <= '0;
      train_frames_q <= '0;
`ifdef TX_ERR_INJECT_EN
      lfsr_q    <= LFSR_SEED;
      inj_q     <= 1'b0;
      err_cnt_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      train_q        <= train_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_sof_q        <= m_sof_d;
      m_eof_q        <= m_eof_d;
      m_train_q      <= m_train_d;
      data_frames_q  <= data_frames_d;
      train_frames_q <= train_frames_d;
`ifdef TX_ERR_INJECT_EN
      lfsr_q    <= lfsr_d;
      inj_q     <= inj_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.s_ready   = (state_q == ST_DATA) && load;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_sof     = m_sof_q;
  assign bus.m_eof     = m_eof_q;
  assign bus.m_train   = m_train_q;
  assign tx_state      = state_q;
  assign data_frames   = data_frames_q;
  assign train_frames  = train_frames_q;

endmodule

// File: tb/tb_link_frame_tx.sv
// Directed self-checking bench for link_frame_tx.
// Build with +define+TX_ERR_INJECT_EN to also cover CRC error injection.
module tb_link_frame_tx;

  localparam int          FW = 8;
  localparam logic [15:0] TP = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b0;
  logic [1:0]  tx_state;
  logic [31:0] data_frames;
  logic [31:0] train_frames;
`ifdef TX_ERR_INJECT_EN
  logic [15:0] err_prob = 16'h0;
  logic [31:0] err_injected;
`endif

  link_frame_if bus();

  always #5 clk = ~clk;

  link_frame_tx #(
    .FRAME_WORDS  (FW),
    .TRAIN_PATTERN(TP),
    .LFSR_SEED    (32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_up     (link_up),
    .bus         (bus.master),
`ifdef TX_ERR_INJECT_EN
    .err_prob    (err_prob),
    .err_injected(err_injected),
`endif
    .tx_state    (tx_state),
    .data_frames (data_frames),
    .train_frames(train_frames)
  );

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        train;
    logic        valid;
    int          cyc;
  } word_t;

  word_t       cap[$];
  logic [15:0] src_q[$];
  int          acc_cyc[$];
  int          cyc;
  int          n_chk = 0;
  int          n_fail = 0;
  word_t       cur_w, prv_w;
  logic        prv_ready, was_stall, sready_seen;

  // Byte-serial reference CRC-16/CCITT-FALSE (big-endian bytes per word).
  function automatic logic [15:0] crc_model(input logic [15:0] w[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (w[i]) begin
      for (int b = 1; b >= 0; b--) begin
        logic [7:0] by;
        by = w[i][8*b +: 8];
        c  = c ^ {by, 8'h00};
        for (int k = 0; k < 8; k++)
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic cycle();
    bus.s_valid = (src_q.size() > 0);
    bus.s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
    @(negedge clk);
    prv_w = cur_w;
    cur_w = '{data: bus.m_data, sof: bus.m_sof, eof: bus.m_eof,
              train: bus.m_train, valid: bus.m_valid, cyc: cyc};
    was_stall = prv_w.valid && !prv_ready;
    prv_ready = bus.m_ready;
    if (bus.s_ready) sready_seen = 1'b1;
    if (bus.m_valid && bus.m_ready) cap.push_back(cur_w);
    if (bus.s_valid && bus.s_ready) begin
      void'(src_q.pop_front());
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    bus.s_valid = 1'b0;
    bus.s_data  = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap.delete();
    acc_cyc.delete();
    cyc         = 0;
    sready_seen = 1'b0;
    cur_w       = '{data: 16'h0, sof: 1'b0, eof: 1'b0, train: 1'b0,
                    valid: 1'b0, cyc: 0};
    prv_ready   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({bus.m_valid, bus.m_sof, bus.m_eof, bus.m_train, bus.s_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.m_valid, bus.m_sof, bus.m_eof, bus.m_train, bus.s_ready});
    end
    n_chk++;
    if (bus.m_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_m_data: got %h want 0000", bus.m_data);
    end
    n_chk++;
    if (tx_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", tx_state);
    end
    n_chk++;
    if (data_frames !== 32'd0 || train_frames !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0",
               data_frames, train_frames);
    end
  endtask

  task automatic test_training();
    logic [15:0] tw[$];
    logic [15:0] tcrc;
    int          inc[$];
    logic [31:0] last;
    do_reset();
    link_up     = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < FW; i++) tw.push_back(TP);
    tcrc = crc_model(tw);
    last = 32'd0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (train_frames !== last) begin
        inc.push_back(cyc);
        last = train_frames;
      end
    end
    n_chk++;
    if (cap.size() < 36) begin
      n_fail++;
      $display("FAIL train_count: got %0d words want >=36", cap.size());
    end
    for (int j = 0; j < 36 && j < cap.size(); j++) begin
      logic [15:0] ed;
      int          i;
      i  = j % 9;
      ed = (i < 8) ? TP : tcrc;
      n_chk++;
      if (cap[j].data !== ed || cap[j].sof !== (i == 0) ||
          cap[j].eof !== (i == 8) || cap[j].train !== 1'b1) begin
        n_fail++;
        $display("FAIL train_word[%0d]: got %h s%b e%b t%b want %h s%b e%b t1",
                 j, cap[j].data, cap[j].sof, cap[j].eof, cap[j].train,
                 ed, i == 0, i == 8);
      end
    end
    n_chk++;
    if (inc.size() < 3) begin
      n_fail++;
      $display("FAIL train_incs: got %0d increments want >=3", inc.size());
    end
    for (int i = 1; i < inc.size(); i++) begin
      n_chk++;
      if (inc[i] - inc[i-1] !== 9) begin
        n_fail++;
        $display("FAIL train_period: got %0d cycles want 9", inc[i] - inc[i-1]);
      end
    end
    n_chk++;
    if (sready_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL train_s_ready: got 1 want 0");
    end
  endtask

  task automatic test_data_frame();
    logic [15:0] pl[$];
    logic [15:0] dcrc;
    int          k;
    do_reset();
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= FW; i++) src_q.push_back(16'(i));
    pl   = src_q;
    dcrc = crc_model(pl);
    k    = 0;
    while (data_frames !== 32'd1 && k < 40) begin cycle(); k++; end
    cycle();
    cycle();
    n_chk++;
    if (cap.size() !== 9) begin
      n_fail++;
      $display("FAIL data_count: got %0d words want 9", cap.size());
    end
    for (int i = 0; i < 9 && i < cap.size(); i++) begin
      logic [15:0] ed;
      ed = (i < 8) ? pl[i] : dcrc;
      n_chk++;
      if (cap[i].data !== ed || cap[i].sof !== (i == 0) ||
          cap[i].eof !== (i == 8) || cap[i].train !== 1'b0) begin
        n_fail++;
        $display("FAIL data_word[%0d]: got %h s%b e%b t%b want %h s%b e%b t0",
                 i, cap[i].data, cap[i].sof, cap[i].eof, cap[i].train,
                 ed, i == 0, i == 8);
      end
    end
    n_chk++;
    if (cap.size() == 0 || acc_cyc.size() == 0 ||
        cap[0].cyc !== acc_cyc[0] + 1) begin
      n_fail++;
      $display("FAIL data_latency: got out cycle %0d want %0d",
               cap.size() ? cap[0].cyc : -1,
               acc_cyc.size() ? acc_cyc[0] + 1 : -1);
    end
    n_chk++;
    if (data_frames !== 32'd1 || train_frames !== 32'd0) begin
      n_fail++;
      $display("FAIL data_counters: got %0d/%0d want 1/0",
               data_frames, train_frames);
    end
    n_chk++;
    if (tx_state !== 2'd0) begin
      n_fail++;
      $display("FAIL data_idle_state: got %0d want 0", tx_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pl[$];
    logic [15:0] c0, c1;
    int          k;
    do_reset();
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 2*FW; i++) src_q.push_back(16'h0100 + 16'(i));
    pl = src_q;
    c0 = crc_model(pl[0:7]);
    c1 = crc_model(pl[8:15]);
    k  = 0;
    while (data_frames !== 32'd2 && k < 60) begin cycle(); k++; end
    n_chk++;
    if (cap.size() !== 18) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words want 18", cap.size());
    end
    for (int j = 0; j < 18 && j < cap.size(); j++) begin
      logic [15:0] ed;
      int          i;
      i  = j % 9;
      ed = (i < 8) ? pl[(j/9)*8 + i] : ((j < 9) ? c0 : c1);
      n_chk++;
      if (cap[j].data !== ed || cap[j].sof !== (i == 0) || cap[j].eof !== (i == 8)) begin
        n_fail++;
        $display("FAIL b2b_word[%0d]: got %h s%b e%b want %h s%b e%b",
                 j, cap[j].data, cap[j].sof, cap[j].eof, ed, i == 0, i == 8);
      end
    end
    n_chk++;
    if (cap.size() < 10 || cap[9].cyc !== cap[8].cyc + 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got sof cycle %0d want %0d",
               cap.size() > 9 ? cap[9].cyc : -1,
               cap.size() > 8 ? cap[8].cyc + 1 : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pl[$];
    logic [15:0] dcrc;
    logic [31:0] pat;
    int          k, stalls;
    do_reset();
    link_up = 1'b1;
    pat     = 32'hB2E4_D369;
    pl      = '{16'hBEEF, 16'h0000, 16'hFFFF, 16'h8001,
                16'h1357, 16'h2468, 16'hC3A5, 16'h7E7E};
    src_q   = pl;
    dcrc    = crc_model(pl);
    k       = 0;
    stalls  = 0;
    while (data_frames !== 32'd1 && k < 80) begin
      bus.m_ready = pat[k % 32];
      cycle();
      k++;
      if (was_stall) begin
        stalls++;
        n_chk++;
        if ({cur_w.data, cur_w.sof, cur_w.eof, cur_w.train, cur_w.valid} !==
            {prv_w.data, prv_w.sof, prv_w.eof, prv_w.train, prv_w.valid}) begin
          n_fail++;
          $display("FAIL bp_hold: got %h/%b%b%b%b want %h/%b%b%b%b",
                   cur_w.data, cur_w.sof, cur_w.eof, cur_w.train, cur_w.valid,
                   prv_w.data, prv_w.sof, prv_w.eof, prv_w.train, prv_w.valid);
        end
      end
    end
    bus.m_ready = 1'b1;
    n_chk++;
    if (stalls == 0 || cap.size() !== 9) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words %0d stalls want 9 words >0 stalls",
               cap.size(), stalls);
    end
    for (int i = 0; i < 9 && i < cap.size(); i++) begin
      logic [15:0] ed;
      ed = (i < 8) ? pl[i] : dcrc;
      n_chk++;
      if (cap[i].data !== ed || cap[i].sof !== (i == 0) || cap[i].eof !== (i == 8)) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got %h s%b e%b want %h s%b e%b",
                 i, cap[i].data, cap[i].sof, cap[i].eof, ed, i == 0, i == 8);
      end
    end
  endtask

  task automatic test_link_drop();
    logic [15:0] pl[$];
    logic [15:0] tw[$];
    logic [15:0] dcrc, tcrc;
    int          k;
    do_reset();
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 2*FW; i++) src_q.push_back(16'h2000 + 16'(i));
    pl = src_q;
    for (int i = 0; i < FW; i++) tw.push_back(TP);
    dcrc = crc_model(pl[0:7]);
    tcrc = crc_model(tw);
    k    = 0;
    while (train_frames !== 32'd1 && k < 60) begin
      cycle();
      k++;
      if (cap.size() >= 3) link_up = 1'b0;
    end
    n_chk++;
    if (cap.size() < 18) begin
      n_fail++;
      $display("FAIL drop_count: got %0d words want >=18", cap.size());
    end
    for (int j = 0; j < 18 && j < cap.size(); j++) begin
      logic [15:0] ed;
      logic        et;
      int          i;
      i  = j % 9;
      et = (j >= 9);
      ed = et ? ((i < 8) ? TP : tcrc) : ((i < 8) ? pl[i] : dcrc);
      n_chk++;
      if (cap[j].data !== ed || cap[j].sof !== (i == 0) ||
          cap[j].eof !== (i == 8) || cap[j].train !== et) begin
        n_fail++;
        $display("FAIL drop_word[%0d]: got %h s%b e%b t%b want %h s%b e%b t%b",
                 j, cap[j].data, cap[j].sof, cap[j].eof, cap[j].train,
                 ed, i == 0, i == 8, et);
      end
    end
    n_chk++;
    if (src_q.size() !== 8 || data_frames !== 32'd1) begin
      n_fail++;
      $display("FAIL drop_consumed: got %0d left %0d frames want 8 left 1 frame",
               src_q.size(), data_frames);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pl[$];
    logic [15:0] dcrc;
    int          k;
    do_reset();
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 2*FW; i++) src_q.push_back(16'h3000 + 16'(i));
    k = 0;
    while (cap.size() < 14 && k < 60) begin cycle(); k++; end
    n_chk++;
    if (data_frames !== 32'd1) begin
      n_fail++;
      $display("FAIL rmid_pre: got %0d frames want 1", data_frames);
    end
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({bus.m_valid, bus.m_sof, bus.m_eof, bus.m_train, bus.s_ready} !== 5'b0 ||
        bus.m_data !== 16'h0 || tx_state !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got %b %h st%0d want 00000 0000 st0",
               {bus.m_valid, bus.m_sof, bus.m_eof, bus.m_train, bus.s_ready},
               bus.m_data, tx_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap.delete();
    src_q.delete();
    cur_w.valid = 1'b0;
    for (int i = 0; i < FW; i++) src_q.push_back(16'h4000 + 16'(i));
    pl   = src_q;
    dcrc = crc_model(pl);
    n_chk++;
    if (data_frames !== 32'd0 || train_frames !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_counters: got %0d/%0d want 0/0",
               data_frames, train_frames);
    end
    k = 0;
    while (data_frames !== 32'd1 && k < 40) begin cycle(); k++; end
    n_chk++;
    if (cap.size() !== 9 || cap[0].sof !== 1'b1 || cap[0].data !== 16'h4000 ||
        cap[8].data !== dcrc || cap[8].eof !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_frame: got %0d words first %h sof%b crc %h want 9 4000 sof1 crc %h",
               cap.size(), cap.size() ? cap[0].data : 16'h0,
               cap.size() ? cap[0].sof : 1'b0,
               cap.size() > 8 ? cap[8].data : 16'h0, dcrc);
    end
  endtask

`ifdef TX_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [15:0] pl[$];
    logic [15:0] c0, c1, c2;
    int          k;
    err_prob = 16'hFFFF;
    do_reset();
    link_up     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3*FW; i++) pl.push_back(16'h5000 + 16'(i*3));
    c0 = crc_model(pl[0:7]);
    c1 = crc_model(pl[8:15]);
    c2 = crc_model(pl[16:23]);
    src_q = pl[0:15];
    k = 0;
    while (data_frames !== 32'd2 && k < 60) begin cycle(); k++; end
    n_chk++;
    if (cap.size() !== 18 || cap[8].data !== (c0 ^ 16'h1) ||
        cap[17].data !== (c1 ^ 16'h1)) begin
      n_fail++;
      $display("FAIL inj_crc: got %0d words %h %h want 18 %h %h", cap.size(),
               cap.size() > 8 ? cap[8].data : 16'h0,
               cap.size() > 17 ? cap[17].data : 16'h0, c0 ^ 16'h1, c1 ^ 16'h1);
    end
    n_chk++;
    if (err_injected !== data_frames) begin
      n_fail++;
      $display("FAIL inj_count: got %0d want %0d", err_injected, data_frames);
    end
    err_prob = 16'h0;
    src_q    = pl[16:23];
    k = 0;
    while (data_frames !== 32'd3 && k < 40) begin cycle(); k++; end
    n_chk++;
    if (cap.size() !== 27 || cap[26].data !== c2 || err_injected !== 32'd2) begin
      n_fail++;
      $display("FAIL inj_off: got %0d words %h cnt %0d want 27 %h cnt 2",
               cap.size(), cap.size() > 26 ? cap[26].data : 16'h0,
               err_injected, c2);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'h0;
    test_reset();
    test_training();
    test_data_frame();
    test_back_to_back();
    test_backpressure();
    test_link_drop();
    test_reset_mid();
`ifdef TX_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
